// File: rtl/w_writeback_stage.sv
// w_writeback_stage: M->W pipeline register, writeback source select,
// load extension, link-address offset and retired-instruction counter.
// Optional feature macro: W_LOAD_EXT_EN (byte/halfword load extension).
module w_writeback_stage #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned LINK_OFFSET = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              W_en,
    input  logic              W_flush,
    input  logic              M_valid,
    input  logic [DATA_W-1:0] M_ans,
    input  logic [DATA_W-1:0] M_Rdata,
    input  logic [DATA_W-1:0] M_pc,
    input  logic [DATA_W-1:0] M_hilo,
    input  logic [ADDR_W-1:0] M_A3,
    input  logic              M_we,
    input  logic [1:0]        M_s_Wdata,
    input  logic [2:0]        M_load_type,
    input  logic [1:0]        M_byte_off,
    output logic [DATA_W-1:0] W_Wdata,
    output logic [ADDR_W-1:0] W_A3,
    output logic              W_we,
    output logic              W_valid,
    output logic [DATA_W-1:0] W_pc,
    output logic [CNT_W-1:0]  W_retired
);

    localparam logic [1:0] SRC_ANS   = 2'b00;
    localparam logic [1:0] SRC_RDATA = 2'b01;
    localparam logic [1:0] SRC_LINK  = 2'b10;
    localparam logic [1:0] SRC_HILO  = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ans_q, ans_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] hilo_q, hilo_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic              we_q, we_d;
    logic [1:0]        src_q, src_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] load_data;

`ifdef W_LOAD_EXT_EN
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic [2:0]        load_type_q, load_type_d;
    logic [1:0]        byte_off_q, byte_off_d;
    logic [DATA_W-1:0] byte_shift;
    logic [DATA_W-1:0] half_shift;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
`else
    logic unused_load_inputs;
    assign unused_load_inputs = ^{M_load_type, M_byte_off};
`endif

    // Stage registers and retire counter, synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            ans_q       <= '0;
            rdata_q     <= '0;
            pc_q        <= '0;
            hilo_q      <= '0;
            a3_q        <= '0;
            we_q        <= 1'b0;
            src_q       <= SRC_ANS;
            cnt_q       <= '0;
`ifdef W_LOAD_EXT_EN
            load_type_q <= 3'b000;
            byte_off_q  <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            ans_q       <= ans_d;
            rdata_q     <= rdata_d;
            pc_q        <= pc_d;
            hilo_q      <= hilo_d;
            a3_q        <= a3_d;
            we_q        <= we_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
`ifdef W_LOAD_EXT_EN
            load_type_q <= load_type_d;
            byte_off_q  <= byte_off_d;
`endif
        end
    end

    // Next state: flush beats capture beats hold; count the outgoing valid instruction
    always_comb begin
        state_d = state_q;
        ans_d   = ans_q;
        rdata_d = rdata_q;
        pc_d    = pc_q;
        hilo_d  = hilo_q;
        a3_d    = a3_q;
        we_d    = we_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
`ifdef W_LOAD_EXT_EN
        load_type_d = load_type_q;
        byte_off_d  = byte_off_q;
`endif
        if (W_flush) begin
            state_d = ST_EMPTY;
            we_d    = 1'b0;
        end else if (W_en) begin
            state_d = M_valid ? ST_FULL : ST_EMPTY;
            ans_d   = M_ans;
            rdata_d = M_Rdata;
            pc_d    = M_pc;
            hilo_d  = M_hilo;
            a3_d    = M_A3;
            we_d    = M_we;
            src_d   = M_s_Wdata;
`ifdef W_LOAD_EXT_EN
            load_type_d = M_load_type;
            byte_off_d  = M_byte_off;
`endif
        end
        if ((W_flush || W_en) && (state_q == ST_FULL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef W_LOAD_EXT_EN
    assign byte_shift = rdata_q >> {byte_off_q, 3'b000};
    assign half_shift = rdata_q >> {byte_off_q[1], 4'b0000};
    assign byte_v     = byte_shift[7:0];
    assign half_v     = half_shift[15:0];

    // Byte/halfword selection with sign or zero extension; unknown types pass the word
    always_comb begin
        load_data = rdata_q;
        case (load_type_q)
            LT_LB:   load_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LT_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_v};
            LT_LH:   load_data = {{(DATA_W-16){half_v[15]}}, half_v};
            LT_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_v};
            default: load_data = rdata_q;
        endcase
    end
`else
    assign load_data = rdata_q;
`endif

    // Writeback source mux from registered state
    always_comb begin
        W_Wdata = ans_q;
        case (src_q)
            SRC_ANS:   W_Wdata = ans_q;
            SRC_RDATA: W_Wdata = load_data;
            SRC_LINK:  W_Wdata = pc_q + DATA_W'(LINK_OFFSET);
            SRC_HILO:  W_Wdata = hilo_q;
            default:   W_Wdata = ans_q;
        endcase
    end

    assign W_valid   = (state_q == ST_FULL);
    assign W_we      = we_q & W_valid & (a3_q != '0);
    assign W_A3      = a3_q;
    assign W_pc      = pc_q;
    assign W_retired = cnt_q;

endmodule

// File: tb/tb_w_writeback_stage.sv
// Directed bench for w_writeback_stage; a second instance with CNT_W=2 checks counter wrap.
module tb_w_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        reset2;
    logic        W_en;
    logic        W_flush;
    logic        M_valid;
    logic [31:0] M_ans;
    logic [31:0] M_Rdata;
    logic [31:0] M_pc;
    logic [31:0] M_hilo;
    logic [4:0]  M_A3;
    logic        M_we;
    logic [1:0]  M_s_Wdata;
    logic [2:0]  M_load_type;
    logic [1:0]  M_byte_off;

    logic [31:0] W_Wdata, W_pc;
    logic [4:0]  W_A3;
    logic        W_we, W_valid;
    logic [31:0] W_retired;

    logic [31:0] w2_Wdata, w2_pc;
    logic [4:0]  w2_A3;
    logic        w2_we, w2_valid;
    logic [1:0]  w2_retired;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    w_writeback_stage u_dut (
        .clk(clk), .reset(reset), .W_en(W_en), .W_flush(W_flush),
        .M_valid(M_valid), .M_ans(M_ans), .M_Rdata(M_Rdata), .M_pc(M_pc),
        .M_hilo(M_hilo), .M_A3(M_A3), .M_we(M_we), .M_s_Wdata(M_s_Wdata),
        .M_load_type(M_load_type), .M_byte_off(M_byte_off),
        .W_Wdata(W_Wdata), .W_A3(W_A3), .W_we(W_we), .W_valid(W_valid),
        .W_pc(W_pc), .W_retired(W_retired)
    );

    w_writeback_stage #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .reset(reset2), .W_en(W_en), .W_flush(W_flush),
        .M_valid(M_valid), .M_ans(M_ans), .M_Rdata(M_Rdata), .M_pc(M_pc),
        .M_hilo(M_hilo), .M_A3(M_A3), .M_we(M_we), .M_s_Wdata(M_s_Wdata),
        .M_load_type(M_load_type), .M_byte_off(M_byte_off),
        .W_Wdata(w2_Wdata), .W_A3(w2_A3), .W_we(w2_we), .W_valid(w2_valid),
        .W_pc(w2_pc), .W_retired(w2_retired)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ans, input logic [31:0] rd,
                         input logic [31:0] pc, input logic [31:0] hilo, input logic [4:0] a3,
                         input logic we, input logic [1:0] s, input logic [2:0] lt,
                         input logic [1:0] off);
        W_en = 1'b1; W_flush = 1'b0;
        M_valid = v; M_ans = ans; M_Rdata = rd; M_pc = pc; M_hilo = hilo;
        M_A3 = a3; M_we = we; M_s_Wdata = s; M_load_type = lt; M_byte_off = off;
    endtask

    task automatic randomize_inputs();
        M_valid = 1'($urandom); M_ans = $urandom; M_Rdata = $urandom; M_pc = $urandom;
        M_hilo = $urandom; M_A3 = 5'($urandom); M_we = 1'($urandom);
        M_s_Wdata = 2'($urandom); M_load_type = 3'($urandom); M_byte_off = 2'($urandom);
    endtask

    // Load capture then compare the writeback word
    task automatic load_case(input string tag, input logic [2:0] lt, input logic [1:0] off,
                             input logic [31:0] exp_ext, input logic [31:0] exp_cnt);
        drive(1'b1, 32'h0, 32'h80FF_7F01, 32'h100, 32'h0, 5'd4, 1'b1, 2'b01, lt, off);
        tick();
`ifdef W_LOAD_EXT_EN
        check(tag, 64'(W_Wdata), 64'(exp_ext));
`else
        check(tag, 64'(W_Wdata), 64'h80FF_7F01);
`endif
        check({tag, "_cnt"}, 64'(W_retired), 64'(exp_cnt));
    endtask

    initial begin
        reset = 1'b0; reset2 = 1'b0;
        W_en = 1'b1; W_flush = 1'($urandom);
        randomize_inputs();
        tick();
        randomize_inputs(); W_flush = 1'($urandom);
        tick();
        check("rst_wdata", 64'(W_Wdata), 64'h0);
        check("rst_a3", 64'(W_A3), 64'h0);
        check("rst_we", 64'(W_we), 64'h0);
        check("rst_valid", 64'(W_valid), 64'h0);
        check("rst_pc", 64'(W_pc), 64'h0);
        check("rst_retired", 64'(W_retired), 64'h0);
        check("rst_retired_c2", 64'(w2_retired), 64'h0);

        reset = 1'b1;
        drive(1'b1, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 5'd8, 1'b1, 2'b00, 3'b000, 2'b00);
        tick();
        check("ans_wdata", 64'(W_Wdata), 64'h1234_5678);
        check("ans_we", 64'(W_we), 64'h1);
        check("ans_valid", 64'(W_valid), 64'h1);
        check("ans_a3", 64'(W_A3), 64'h8);
        check("ans_retired", 64'(W_retired), 64'h0);

        drive(1'b1, 32'h0, 32'h0, 32'h0000_3000, 32'h0, 5'd31, 1'b1, 2'b10, 3'b000, 2'b00);
        tick();
        check("link_wdata", 64'(W_Wdata), 64'h0000_3008);
        check("link_pc", 64'(W_pc), 64'h0000_3000);
        check("link_retired", 64'(W_retired), 64'h1);

        drive(1'b1, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 5'd31, 1'b1, 2'b10, 3'b000, 2'b00);
        tick();
        check("link_wrap", 64'(W_Wdata), 64'h0000_0004);
        check("link_wrap_retired", 64'(W_retired), 64'h2);

        load_case("lb_off3", 3'b001, 2'd3, 32'hFFFF_FF80, 32'd3);
        load_case("lbu_off3", 3'b010, 2'd3, 32'h0000_0080, 32'd4);
        load_case("lh_off1", 3'b011, 2'd1, 32'h0000_7F01, 32'd5);
        load_case("lhu_off2", 3'b100, 2'd2, 32'h0000_80FF, 32'd6);
        load_case("lb_off0", 3'b001, 2'd0, 32'h0000_0001, 32'd7);
        load_case("lt_other", 3'b111, 2'd1, 32'h80FF_7F01, 32'd8);

        drive(1'b1, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd2, 1'b1, 2'b11, 3'b000, 2'b00);
        tick();
        check("hilo_wdata", 64'(W_Wdata), 64'hDEAD_BEEF);
        check("hilo_retired", 64'(W_retired), 64'd9);

        drive(1'b1, 32'h55, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 2'b00, 3'b000, 2'b00);
        tick();
        check("a3zero_we", 64'(W_we), 64'h0);
        check("a3zero_valid", 64'(W_valid), 64'h1);

        drive(1'b1, 32'hA5A5_A5A5, 32'h0, 32'h400, 32'h0, 5'd3, 1'b1, 2'b00, 3'b000, 2'b00);
        tick();
        check("pre_stall_retired", 64'(W_retired), 64'd11);

        W_en = 1'b0; W_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            tick();
            check("stall_wdata", 64'(W_Wdata), 64'hA5A5_A5A5);
            check("stall_a3", 64'(W_A3), 64'h3);
            check("stall_we", 64'(W_we), 64'h1);
            check("stall_valid", 64'(W_valid), 64'h1);
            check("stall_pc", 64'(W_pc), 64'h400);
            check("stall_retired", 64'(W_retired), 64'd11);
        end

        drive(1'b1, 32'h77, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 2'b00, 3'b000, 2'b00);
        W_flush = 1'b1;
        tick();
        check("flush_valid", 64'(W_valid), 64'h0);
        check("flush_we", 64'(W_we), 64'h0);
        check("flush_retired", 64'(W_retired), 64'd12);

        // Five valid captures with one bubble; narrow counter released here
        reset2 = 1'b1;
        drive(1'b1, 32'h1, 32'h0, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00, 3'b000, 2'b00);
        tick();
        drive(1'b1, 32'h2, 32'h0, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00, 3'b000, 2'b00);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00, 3'b000, 2'b00);
        tick();
        check("bubble_valid", 64'(W_valid), 64'h0);
        check("bubble_we", 64'(W_we), 64'h0);
        check("bubble_retired", 64'(W_retired), 64'd14);
        drive(1'b1, 32'h3, 32'h0, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00, 3'b000, 2'b00);
        tick();
        check("after_bubble_retired", 64'(W_retired), 64'd14);
        drive(1'b1, 32'h4, 32'h0, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00, 3'b000, 2'b00);
        tick();
        drive(1'b1, 32'h5, 32'h0, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00, 3'b000, 2'b00);
        tick();
        check("last_wdata", 64'(W_Wdata), 64'h5);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 1'b0, 2'b00, 3'b000, 2'b00);
        tick();
        check("five_retired", 64'(W_retired), 64'd17);
        check("five_retired_c2", 64'(w2_retired), 64'd1);

        // Reset during stall overrides hold
        drive(1'b1, 32'h9, 32'h0, 32'h8, 32'h0, 5'd9, 1'b1, 2'b00, 3'b000, 2'b00);
        tick();
        W_en = 1'b0; W_flush = 1'b1; reset = 1'b0;
        tick();
        check("rst_mid_valid", 64'(W_valid), 64'h0);
        check("rst_mid_retired", 64'(W_retired), 64'h0);
        check("rst_mid_wdata", 64'(W_Wdata), 64'h0);
        check("rst_mid_pc", 64'(W_pc), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
